mem_port_arbiter: RTL and testbench

//   Shares one memory port between the instruction-fetch stage (IF) and the data-memory stage (D) of the pipelined rv32i core.

---
 rtl/mem_arb_pkg.sv | 14 +
 rtl/arb_starve_ctr.sv | 30 +++
 rtl/mem_port_arbiter.sv | 125 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types for the IF/D memory port arbiter
package mem_arb_pkg;
  localparam int MEM_XLEN = 32;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} arb_state_e;
  typedef enum logic {OWN_IF, OWN_D} owner_e;

  typedef struct packed {
    logic                we;
    logic [MEM_XLEN-1:0] addr;
    logic [MEM_XLEN-1:0] wdata;
    logic [3:0]          be;
  } mem_req_t;
endpackage

// File: rtl/arb_starve_ctr.sv
// rtl/arb_starve_ctr.sv - saturating count of D grants taken while IF waits
module arb_starve_ctr
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic if_req,
  input  logic if_gnt,
  input  logic d_gnt,
  output logic force_if
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (!if_req || if_gnt) begin
      count <= '0;
    end else if (d_gnt && (count != LIMIT)) begin
      count <= count + 1'b1;
    end
  end

  assign force_if = (count == LIMIT);
endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - one-outstanding arbiter sharing a memory port between IF and D
// Optional IF starvation guard enabled by defining ARB_STARVE_GUARD_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [XLEN-1:0] if_rdata,
  output logic            if_stall,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [XLEN-1:0] d_addr,
  input  logic [XLEN-1:0] d_wdata,
  input  logic [3:0]      d_be,
  output logic            d_gnt,
  output logic            d_rvalid,
  output logic [XLEN-1:0] d_rdata,
  output logic            d_stall,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_be,
  input  logic            mem_ready,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            busy
);
  arb_state_e state, state_next;
  owner_e     owner, owner_next;
  mem_req_t   sel;
  logic       force_if;
  logic       accept;
  logic       resp;

`ifdef ARB_STARVE_GUARD_EN
  arb_starve_ctr #(.STARVE_LIMIT(STARVE_LIMIT)) u_starve (
    .clk      (clk),
    .reset    (reset),
    .if_req   (if_req),
    .if_gnt   (if_gnt),
    .d_gnt    (d_gnt),
    .force_if (force_if)
  );
`else
  // Strict D priority; the limit only matters when the guard is built in.
  assign force_if = (STARVE_LIMIT < 0);
`endif

  always_comb begin
    state_next = state;
    owner_next = owner;
    unique case (state)
      IDLE: begin
        if (d_req || if_req) begin
          state_next = REQ;
          owner_next = (d_req && !(if_req && force_if)) ? OWN_D : OWN_IF;
        end
      end
      REQ:     if (mem_ready) state_next = WAIT;
      WAIT:    if (mem_rvalid) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      owner    <= OWN_D;
      if_rdata <= '0;
      d_rdata  <= '0;
    end else begin
      state <= state_next;
      owner <= owner_next;
      if ((state == WAIT) && mem_rvalid) begin
        if (owner == OWN_IF) begin
          if_rdata <= mem_rdata;
        end else if (!d_we) begin
          d_rdata <= mem_rdata;
        end
      end
    end
  end

  // Request fields come straight from the owner's held inputs, zero outside REQ.
  always_comb begin
    sel = '0;
    if (state == REQ) begin
      if (owner == OWN_D) begin
        sel.we    = d_we;
        sel.addr  = d_addr;
        sel.wdata = d_wdata;
        sel.be    = d_be;
      end else begin
        sel.addr = if_addr;
      end
    end
  end

  assign mem_req   = (state == REQ);
  assign mem_we    = sel.we;
  assign mem_addr  = sel.addr;
  assign mem_wdata = sel.wdata;
  assign mem_be    = sel.be;

  assign accept    = (state == REQ) && mem_ready && !reset;
  assign resp      = (state == RESP) && !reset;
  assign if_gnt    = accept && (owner == OWN_IF);
  assign d_gnt     = accept && (owner == OWN_D);
  assign if_rvalid = resp && (owner == OWN_IF);
  assign d_rvalid  = resp && (owner == OWN_D);
  assign if_stall  = if_req && !if_rvalid;
  assign d_stall   = d_req && !d_rvalid;
  assign busy      = (state != IDLE);

  a_rvalid_in_wait: assert property (@(posedge clk) disable iff (reset) mem_rvalid |-> (state == WAIT));
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed and randomized self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
  localparam int L = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, if_gnt, if_rvalid, if_stall;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid, d_stall;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [3:0]  d_be;
  logic        mem_req, mem_we, mem_ready, mem_rvalid, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  int total = 0;
  int bad = 0;
  int starve = 0;
  logic [31:0] exp_if_rdata = '0;
  logic [31:0] exp_d_rdata = '0;
  int d_gnt_seen = 0;
  int if_gnt_seen = 0;

  mem_port_arbiter #(.XLEN(32), .STARVE_LIMIT(L)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata), .if_stall(if_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_stall(d_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!reset) begin
      if (d_gnt) d_gnt_seen <= d_gnt_seen + 1;
      if (if_gnt) if_gnt_seen <= if_gnt_seen + 1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit guard_hit();
`ifdef ARB_STARVE_GUARD_EN
    return starve >= L;
`else
    return 1'b0;
`endif
  endfunction

  task automatic new_d_req();
    d_req = 1'b1;
    d_we = 1'($urandom);
    d_addr = $urandom;
    d_wdata = $urandom;
    d_be = 4'($urandom);
  endtask

  task automatic new_if_req();
    if_req = 1'b1;
    if_addr = $urandom;
  endtask

  // Called in the IDLE cycle (just after a falling edge) with at least one request raised.
  task automatic run_txn(input int rdly, input int wdly, input bit renew_d, input bit renew_if,
                         input logic [31:0] rdat);
    bit own_d;
    logic [31:0] e_addr, e_wdata;
    logic [3:0] e_be;
    logic e_we;
    own_d = d_req && !(if_req && guard_hit());
    e_we = own_d ? d_we : 1'b0;
    e_addr = own_d ? d_addr : if_addr;
    e_wdata = own_d ? d_wdata : 32'h0;
    e_be = own_d ? d_be : 4'h0;
    @(negedge clk);
    for (int i = 0; i <= rdly; i++) begin
      if (i > 0) @(negedge clk);
      mem_ready = (i == rdly);
      #1;
      chk("req_mem_req", mem_req, 1);
      chk("req_busy", busy, 1);
      chk("req_mem_we", mem_we, e_we);
      chk("req_mem_addr", mem_addr, e_addr);
      chk("req_mem_wdata", mem_wdata, e_wdata);
      chk("req_mem_be", mem_be, e_be);
      chk("req_if_gnt", if_gnt, mem_ready && !own_d);
      chk("req_d_gnt", d_gnt, mem_ready && own_d);
      chk("req_if_stall", if_stall, if_req);
      chk("req_d_stall", d_stall, d_req);
    end
    if (own_d) starve = if_req ? ((starve < L) ? starve + 1 : L) : 0;
    else starve = 0;
    for (int i = 0; i <= wdly; i++) begin
      @(negedge clk);
      mem_ready = 1'b0;
      mem_rvalid = (i == wdly);
      mem_rdata = mem_rvalid ? rdat : $urandom;
      #1;
      chk("wait_mem_req", mem_req, 0);
      chk("wait_busy", busy, 1);
      chk("wait_gnt", {if_gnt, d_gnt}, 0);
      chk("wait_rvalid", {if_rvalid, d_rvalid}, 0);
    end
    @(negedge clk);
    mem_rvalid = 1'b0;
    mem_rdata = $urandom;
    if (!own_d) exp_if_rdata = rdat;
    else if (!d_we) exp_d_rdata = rdat;
    #1;
    chk("resp_if_rvalid", if_rvalid, !own_d);
    chk("resp_d_rvalid", d_rvalid, own_d);
    chk("resp_if_rdata", if_rdata, exp_if_rdata);
    chk("resp_d_rdata", d_rdata, exp_d_rdata);
    chk("resp_if_stall", if_stall, own_d ? if_req : 1'b0);
    chk("resp_d_stall", d_stall, own_d ? 1'b0 : d_req);
    if (own_d) begin
      if (renew_d) new_d_req(); else d_req = 1'b0;
    end else begin
      if (renew_if) new_if_req(); else if_req = 1'b0;
    end
    @(negedge clk);
    #1;
    chk("idle_busy", busy, 0);
    chk("idle_mem_req", mem_req, 0);
    chk("idle_rvalid", {if_rvalid, d_rvalid}, 0);
  endtask

  initial begin
    int base_d, base_if;
    reset = 1'b1;
    if_req = 1'b1; if_addr = 32'h44; d_req = 1'b1; d_we = 1'b1;
    d_addr = 32'h88; d_wdata = 32'h1234_5678; d_be = 4'hF;
    mem_ready = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;

    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #1;
      chk("rst_mem_req", mem_req, 0);
      chk("rst_busy", busy, 0);
      chk("rst_gnt", {if_gnt, d_gnt}, 0);
      chk("rst_rvalid", {if_rvalid, d_rvalid}, 0);
      chk("rst_mem_fields", {mem_we, mem_be}, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_if_rdata", if_rdata, 0);
      chk("rst_d_rdata", d_rdata, 0);
    end
    @(negedge clk);
    reset = 1'b0; if_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0;
    #1;
    chk("post_rst_busy", busy, 0);

    if_req = 1'b1; if_addr = 32'h0000_0010;
    run_txn(0, 1, 1'b0, 1'b0, 32'h0050_0093);

    new_if_req();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF; d_be = 4'hF;
    run_txn(0, 0, 1'b0, 1'b0, $urandom);
    run_txn(1, 1, 1'b0, 1'b0, $urandom);

    new_d_req();
    run_txn(5, 2, 1'b0, 1'b0, $urandom);

    if_req = 1'b1; if_addr = 32'h0000_0200;
    @(negedge clk);
    mem_ready = 1'b1;
    #1;
    chk("rstw_if_gnt", if_gnt, 1);
    @(negedge clk);
    mem_ready = 1'b0; reset = 1'b1;
    #1;
    chk("rstw_busy_wait", busy, 1);
    @(negedge clk);
    #1;
    chk("rstw_busy_idle", busy, 0);
    chk("rstw_rvalid0", {if_rvalid, d_rvalid}, 0);
    @(negedge clk);
    mem_rvalid = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    #1;
    chk("rstw_rvalid1", {if_rvalid, d_rvalid}, 0);
    @(negedge clk);
    mem_rvalid = 1'b0; if_req = 1'b0; reset = 1'b0;
    exp_if_rdata = '0; exp_d_rdata = '0; starve = 0;
    #1;
    chk("rstw_if_rdata", if_rdata, exp_if_rdata);
    chk("rstw_d_rdata", d_rdata, exp_d_rdata);
    chk("rstw_rvalid2", {if_rvalid, d_rvalid}, 0);
    @(negedge clk);
    #1;
    chk("rstw_idle", {busy, mem_req, if_rvalid, d_rvalid}, 0);

    base_d = d_gnt_seen;
    base_if = if_gnt_seen;
    new_if_req();
    new_d_req();
    for (int t = 0; t < 5; t++) run_txn(0, 0, 1'b1, 1'b0, $urandom);
`ifdef ARB_STARVE_GUARD_EN
    chk("starve_d_grants", d_gnt_seen - base_d, L);
    chk("starve_if_grants", if_gnt_seen - base_if, 1);
`else
    chk("starve_d_grants", d_gnt_seen - base_d, 5);
    chk("starve_if_grants", if_gnt_seen - base_if, 0);
`endif

    for (int r = 0; r < 40; r++) begin
      if (!d_req && ($urandom_range(0, 1) == 1)) new_d_req();
      if (!if_req && ($urandom_range(0, 1) == 1)) new_if_req();
      if (!d_req && !if_req) begin
        if ($urandom_range(0, 1) == 1) new_d_req(); else new_if_req();
      end
      run_txn($urandom_range(0, 3), $urandom_range(0, 2), 1'($urandom), 1'($urandom), $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
